// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default period/width so the PWM block and its
// sequencers agree, plus the fade controller state encoding.
package pwm_pkg;

    localparam int PWM_MAX_VALUE = 1000;
    localparam int PWM_BITS      = 10;

    typedef enum logic {
        IDLE,
        FADE
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Target handoff channel between a fade requester and pwm_fade_ctrl.
// A new target/step_period pair transfers when target_valid && target_ready.
interface pwm_fade_ctrl_if
    import pwm_pkg::*;
#(
    parameter int BITS      = PWM_BITS,
    parameter int STEP_BITS = 16
);
    logic                 target_valid;
    logic                 target_ready;
    logic [BITS-1:0]      target;
    logic [STEP_BITS-1:0] step_period;

    modport master (
        output target_valid,
        output target,
        output step_period,
        input  target_ready
    );

    modport slave (
        input  target_valid,
        input  target,
        input  step_period,
        output target_ready
    );
endinterface

// File: rtl/pwm_tick_gen.sv
// Tick prescaler: registered one-cycle tick every TICK_DIV clocks,
// first tick TICK_DIV clocks after reset release.
module pwm_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);
    localparam int            DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic          tick_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            tick_reg    <= (div_cnt_reg == LAST);
            div_cnt_reg <= (div_cnt_reg == LAST) ? '0 : div_cnt_reg + 1'b1;
        end
    end

    assign tick = tick_reg;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade sequencer: ramps value one LSB per step_period PWM periods,
// changing only at period boundaries. Define PWM_FADE_RETARGET_EN to allow retargeting mid-fade.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int MAX_VALUE = PWM_MAX_VALUE,
    parameter int BITS      = PWM_BITS,
    parameter int TICK_DIV  = 50,
    parameter int STEP_BITS = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    pwm_fade_ctrl_if.slave  req,
    output logic            tick,
    output logic [BITS-1:0] value,
    output logic            busy,
    output logic            done
);
    localparam int              PW       = (MAX_VALUE > 1) ? $clog2(MAX_VALUE) : 1;
    localparam logic [PW-1:0]   PER_LAST = PW'(MAX_VALUE - 1);
    localparam logic [BITS-1:0] VMAX     = BITS'(MAX_VALUE);

    fade_state_t          state_reg;
    logic [PW-1:0]        per_cnt_reg;
    logic [BITS-1:0]      value_reg;
    logic [BITS-1:0]      tgt_reg;
    logic [STEP_BITS-1:0] sp_reg;
    logic [STEP_BITS-1:0] step_cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 boundary;
    logic                 accept;
    logic [BITS-1:0]      target_clamped;
    logic [STEP_BITS-1:0] step_eff;
    logic                 step_due;
    logic [BITS-1:0]      value_stepped;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick)
    );

`ifdef PWM_FADE_RETARGET_EN
    assign req.target_ready = 1'b1;
`else
    assign req.target_ready = (state_reg == IDLE);
`endif

    assign boundary       = tick && (per_cnt_reg == PER_LAST);
    assign accept         = req.target_valid && req.target_ready;
    assign target_clamped = (req.target > VMAX) ? VMAX : req.target;
    assign step_eff       = (req.step_period == '0) ? STEP_BITS'(1) : req.step_period;

    // Value after this cycle's step (if any); a retarget is judged against it.
    assign step_due      = (state_reg == FADE) && boundary && (step_cnt_reg == '0);
    assign value_stepped = !step_due ? value_reg :
                           (tgt_reg > value_reg) ? value_reg + 1'b1 : value_reg - 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            per_cnt_reg  <= '0;
            value_reg    <= '0;
            tgt_reg      <= '0;
            sp_reg       <= '0;
            step_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (tick) begin
                per_cnt_reg <= (per_cnt_reg == PER_LAST) ? '0 : per_cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        tgt_reg <= target_clamped;
                        sp_reg  <= step_eff;
                        if (target_clamped == value_reg) begin
                            done_reg <= 1'b1;
                        end else begin
                            busy_reg     <= 1'b1;
                            step_cnt_reg <= step_eff - 1'b1;
                            state_reg    <= FADE;
                        end
                    end
                end
                FADE: begin
                    if (boundary) begin
                        if (step_cnt_reg != '0) begin
                            step_cnt_reg <= step_cnt_reg - 1'b1;
                        end else begin
                            value_reg    <= value_stepped;
                            step_cnt_reg <= sp_reg - 1'b1;
                            if (value_stepped == tgt_reg) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
`ifdef PWM_FADE_RETARGET_EN
                    // A new target supersedes the running fade, including one finishing now.
                    if (accept) begin
                        tgt_reg <= target_clamped;
                        sp_reg  <= step_eff;
                        if (target_clamped == value_stepped) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= FADE;
                            busy_reg     <= 1'b1;
                            done_reg     <= 1'b0;
                            step_cnt_reg <= step_eff - 1'b1;
                        end
                    end
`endif
                end
            endcase
        end
    end

    assign value = value_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl with MAX_VALUE=10, BITS=4, TICK_DIV=2, STEP_BITS=4.
// Honours PWM_FADE_RETARGET_EN to select the retarget or hold-off scenario.
module tb_pwm_fade_ctrl;
    localparam int MV = 10;
    localparam int TD = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick;
    logic [3:0] value;
    logic       busy;
    logic       done;

    pwm_fade_ctrl_if #(.BITS(4), .STEP_BITS(4)) bus ();

    pwm_fade_ctrl #(
        .MAX_VALUE (MV),
        .BITS      (4),
        .TICK_DIV  (TD),
        .STEP_BITS (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (bus.slave),
        .tick    (tick),
        .value   (value),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: n = clock edges since reset release; the fade is counted in boundaries.
    int n = 0;
    int m_value = 0, m_tgt = 0, m_sp = 1, m_nb = 0;
    bit m_busy = 0, m_done = 0;

    function automatic bit m_ready();
`ifdef PWM_FADE_RETARGET_EN
        return 1'b1;
`else
        return !m_busy;
`endif
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n = 0; m_value = 0; m_tgt = 0; m_sp = 1; m_nb = 0; m_busy = 0; m_done = 0;
        end else begin
            bit bnd, acc;
            int t;
            bnd = (n >= 1) && (n % TD == 0) && ((n / TD) % MV == 0);
            acc = bus.target_valid && m_ready();
            m_done = 0;
            if (m_busy && bnd) begin
                m_nb++;
                if (m_nb % m_sp == 0) begin
                    m_value += (m_tgt > m_value) ? 1 : -1;
                    if (m_value == m_tgt) begin m_busy = 0; m_done = 1; end
                end
            end
            if (acc) begin
                t = (int'(bus.target) > MV) ? MV : int'(bus.target);
                m_sp = (bus.step_period == 0) ? 1 : int'(bus.step_period);
                if (t == m_value) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_tgt = t; m_nb = 0; m_busy = 1; m_done = 0;
                end
            end
            n++;
        end
    end

    int done_cnt = 0;
    int last_val = 0;
    int vals[$];
    int vns[$];

    always @(negedge clock) begin
        chk("tick", tick, (n >= 1 && n % TD == 0) ? 1 : 0);
        chk("value", value, m_value);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("ready", bus.target_ready, m_ready());
        if (done) done_cnt++;
        if (int'(value) != last_val) begin
            vals.push_back(int'(value));
            vns.push_back(n);
            last_val = int'(value);
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_log();
        vals.delete();
        vns.delete();
    endtask

    task automatic send(input int t, input int s);
        step();
        bus.target       = 4'(t);
        bus.step_period  = 4'(s);
        bus.target_valid = 1'b1;
        $display("XACT n=%0d target=%0d sp=%0d value=%0d", n, t, s, value);
        step();
        bus.target_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input string nm);
        int k;
        for (k = 0; k < max; k++) begin
            if (done) break;
            step();
        end
        chk(nm, done, 1);
    endtask

    initial begin
        int d0;
        bus.target_valid = 1'b0;
        bus.target       = '0;
        bus.step_period  = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // reset and idle prescaler
        @(posedge clock); #1;
        chk("tick_edge1", tick, 0);
        @(posedge clock); #1;
        chk("tick_edge2", tick, 1);
        chk("reset_value", value, 0);
        chk("reset_ready", bus.target_ready, 1);
        repeat (30) step();
        chk("idle_no_done", done_cnt, 0);

        // ramp up 0 -> 3, sp=1
        clear_log(); d0 = done_cnt;
        send(3, 1);
        wait_done(100, "ramp_done_timeout");
        chk("ramp_final", value, 3);
        step();
        chk("ramp_done_count", done_cnt - d0, 1);
        chk("ramp_nsteps", vals.size(), 3);
        if (vals.size() == 3) begin
            chk("ramp_v0", vals[0], 1);
            chk("ramp_v2", vals[2], 3);
            chk("ramp_gap1", vns[1] - vns[0], 20);
            chk("ramp_gap2", vns[2] - vns[1], 20);
        end

        // clamp, then no-op request
        send(15, 1);
        wait_done(200, "clamp_done_timeout");
        chk("clamp_final", value, 10);
        send(10, 1);
        chk("noop_done", done, 1);
        chk("noop_busy", busy, 0);
        step();
        chk("noop_done_pulse", done, 0);

        // slow ramp down, then sp=0
        clear_log();
        send(8, 3);
        wait_done(250, "slow_done_timeout");
        chk("slow_final", value, 8);
        if (vns.size() == 2) chk("slow_gap", vns[1] - vns[0], 60);
        else chk("slow_nsteps", vns.size(), 2);
        clear_log();
        send(10, 0);
        wait_done(100, "sp0_done_timeout");
        if (vns.size() == 2) chk("sp0_gap", vns[1] - vns[0], 20);
        else chk("sp0_nsteps", vns.size(), 2);

        // asynchronous reset mid-fade
        send(0, 1);
        repeat (30) step();
        chk("midfade_busy", busy, 1);
        d0 = done_cnt;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_value", value, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tick", tick, 0);
        chk("arst_ready", bus.target_ready, 1);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (40) step();
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_value_after", value, 0);

`ifdef PWM_FADE_RETARGET_EN
        clear_log(); d0 = done_cnt;
        send(8, 1);
        for (int k = 0; k < 200 && value != 4'd5; k++) step();
        chk("rt_reach5", value, 5);
        send(2, 1);
        wait_done(200, "rt_done_timeout");
        chk("rt_final", value, 2);
        step();
        chk("rt_done_count", done_cnt - d0, 1);
        chk("rt_nsteps", vals.size(), 8);
        if (vals.size() == 8) begin
            chk("rt_v5", vals[5], 4);
            chk("rt_v6", vals[6], 3);
            chk("rt_v7", vals[7], 2);
        end
        send(6, 1);
        for (int k = 0; k < 100 && value != 4'd3; k++) step();
        chk("rt_reach3", value, 3);
        send(3, 1);
        chk("rt_same_done", done, 1);
        chk("rt_same_busy", busy, 0);
`else
        d0 = done_cnt;
        send(3, 1);
        repeat (5) step();
        bus.target       = 4'd1;
        bus.step_period  = 4'd1;
        bus.target_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_ready", bus.target_ready, 0);
            step();
        end
        bus.target_valid = 1'b0;
        wait_done(100, "hold_done_timeout");
        chk("hold_final", value, 3);
        step();
        chk("hold_done_count", done_cnt - d0, 1);
`endif

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
